seq_match_detector: RTL

Parametrised serial pattern detector: the next generation of the team's fixed 3-bit Mealy sequence detector. It accepts one bit per qualified clock on `x` and compares the most recent `PAT_LEN` bits against a runtime-loadable pattern. It supports overlapping and non-overlapping detection and keeps a saturating match counter. It sits between a serial bit source and control/status logic that consumes single-cycle `match` pulses.

---
 rtl/seq_match_detector.sv | 105 ++++++++++
 1 files changed

// File: rtl/seq_match_detector.sv
// seq_match_detector
//   Serial pattern detector. Accepts one bit per qualified clock and compares the
//   most recent PAT_LEN accepted bits against a runtime-loadable pattern. Supports
//   overlapping / non-overlapping detection and keeps a saturating match counter.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   x            serial data bit, sampled when in_valid=1
//   in_valid     qualifies x on the current edge
//   pattern      target pattern; bit PAT_LEN-1 is the oldest bit, bit 0 the newest
//   load_pat     latch pattern, discard history (priority over in_valid)
//   overlap      1: overlapping detection, 0: non-overlapping
//   clear        synchronously zero match_count (wins over an increment)
//   match        registered single-cycle hit pulse
//   armed        registered (fill == PAT_LEN)
//   match_count  registered saturating hit counter
module seq_match_detector #(
  parameter int unsigned PAT_LEN = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               x,
  input  logic               in_valid,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               load_pat,
  input  logic               overlap,
  input  logic               clear,
  output logic               match,
  output logic               armed,
  output logic [CNT_W-1:0]   match_count
);

  localparam int unsigned    FillW    = $clog2(PAT_LEN + 1);
  localparam logic [FillW-1:0] FillFull = FillW'(PAT_LEN);

  logic [PAT_LEN-1:0] hist_q, hist_d, hist_n;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [FillW-1:0]   fill_q, fill_d, fill_inc;
  logic               match_q, match_d;
  logic               armed_q, armed_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               hit;

  assign hist_n   = {hist_q[PAT_LEN-2:0], x};
  assign fill_inc = (fill_q == FillFull) ? FillFull : fill_q + FillW'(1);
  // fill gating keeps reset-zero / stale history from producing a false hit
  assign hit      = in_valid & ~load_pat & (fill_inc == FillFull) & (hist_n == pat_q);

  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    match_d = 1'b0;
    count_d = count_q;

    if (load_pat) begin
      pat_d  = pattern;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = hist_n;
      if (hit) begin
        match_d = 1'b1;
        // non-overlap restarts the fill so PAT_LEN fresh bits are needed
        fill_d  = overlap ? FillFull : '0;
        if (count_q != '1) begin
          count_d = count_q + CNT_W'(1);
        end
      end else begin
        fill_d = fill_inc;
      end
    end

    if (clear) begin
      count_d = '0;
    end

    armed_d = (fill_d == FillFull);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= '0;
      pat_q   <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      armed_q <= 1'b0;
      count_q <= '0;
    end else begin
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      armed_q <= armed_d;
      count_q <= count_d;
    end
  end

  assign match       = match_q;
  assign armed       = armed_q;
  assign match_count = count_q;

endmodule
